// File: rtl/lsu_controller.sv
// lsu_controller: sequences one data-memory load/store per core request.
// Latency: start -> mem_req_o next cycle; ack -> done_o next cycle; illegal/trapped -> done_o next cycle.
// Backpressure: mem_req_o held until mem_ack_i or timeout; busy_o stalls the core meanwhile.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word accesses).
module lsu_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        misaligned_o,
  output logic [31:0] load_data_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        mis_q;
  logic [31:0] load_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] maddr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  // Request decode, evaluated from the live inputs while in IDLE.
  logic        illegal_d;
  logic        misal_d;
  logic        fault_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  // Load extraction from the returning read word.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_d;

  // Size decode: lane enables, replicated store data, legality.
  always_comb begin
    illegal_d = 1'b0;
    be_d      = 4'b0000;
    wdata_d   = store_data_i;
    case (funct3_i)
      3'b000, 3'b100: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{store_data_i[7:0]}};
      end
      3'b001, 3'b101: begin
        be_d    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_d = {2{store_data_i[15:0]}};
      end
      3'b010: begin
        be_d    = 4'b1111;
        wdata_d = store_data_i;
      end
      default: illegal_d = 1'b1;
    endcase
    // Unsigned variants exist only for loads.
    if (is_store_i && funct3_i[2]) begin
      illegal_d = 1'b1;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Half needs addr[0]=0, word needs addr[1:0]=0; only meaningful for legal encodings.
  assign misal_d = ~illegal_d &
                   (((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                    ((funct3_i[1:0] == 2'b10) & (|addr_i[1:0])));
`else
  // Misalignment is tolerated: offending low address bits are simply dropped.
  assign misal_d = 1'b0;
`endif

  assign fault_d = illegal_d | misal_d;

  // Lane select and sign/zero extension of the read word.
  always_comb begin
    byte_sel = mem_rdata_i[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_d = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_d = {24'h000000, byte_sel};
      3'b001:  load_d = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_d = {16'h0000, half_sel};
      default: load_d = mem_rdata_i;
    endcase
  end

  // Access sequencer with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mis_q      <= 1'b0;
      load_q     <= 32'h0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      maddr_q    <= 32'h0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          mis_q  <= 1'b0;
          if (start_i) begin
            is_store_q <= is_store_i;
            funct3_q   <= funct3_i;
            off_q      <= addr_i[1:0];
            cnt_q      <= 8'd0;
            if (fault_d) begin
              state_q <= S_FAULT;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              mis_q   <= misal_d;
            end else begin
              state_q <= S_ACCESS;
              req_q   <= 1'b1;
              busy_q  <= 1'b1;
              we_q    <= is_store_i;
              maddr_q <= {addr_i[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= is_store_i ? wdata_d : 32'h0;
            end
          end
        end
        S_ACCESS: begin
          // Ack is checked first so an ack on the limit cycle completes normally.
          if (mem_ack_i || (cnt_q + 8'd1 == TO_LIMIT)) begin
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= 32'h0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            done_q  <= 1'b1;
            if (mem_ack_i) begin
              state_q <= S_DONE;
              if (!is_store_q) begin
                load_q <= load_d;
              end
            end else begin
              state_q <= S_FAULT;
              err_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE, S_FAULT: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          mis_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign misaligned_o = mis_q;
  assign load_data_o  = load_q;
  assign mem_req_o    = req_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = maddr_q;
  assign mem_be_o     = be_q;
  assign mem_wdata_o  = wdata_q;

endmodule
